ex_muldiv_seq: RTL and testbench



---
 rtl/ex_muldiv_seq_pkg.sv | 26 ++
 rtl/md_iter_step.sv | 46 ++++
 rtl/ex_muldiv_seq.sv | 209 ++++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared encodings for the EX-stage multi-cycle multiply/divide sequencer:
// op codes, FSM states and the EX-control bit that flags a muldiv instruction.
package ex_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_OP_MUL   = 2'b00,
        MD_OP_MULHU = 2'b01,
        MD_OP_DIVU  = 2'b10,
        MD_OP_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_MUL  = 2'b01,
        MD_ST_DIV  = 2'b10,
        MD_ST_DONE = 2'b11
    } md_state_e;

    localparam int EX_CTRL_MULDIV_BIT = 5;

    // Ops 10/11 are the divide family; bit 1 of the encoding selects it.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the sequencer: a shift-add multiply step
// and a restoring-division step, both retiring a single bit.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] mul_prod,
    input  logic [WIDTH-1:0]   mul_mcand,
    input  logic [WIDTH:0]     div_rem,
    input  logic [WIDTH-1:0]   div_quot,
    input  logic [WIDTH-1:0]   div_divisor,
    output logic [2*WIDTH-1:0] mul_prod_next,
    output logic [WIDTH:0]     div_rem_next,
    output logic [WIDTH-1:0]   div_quot_next
);

    logic [WIDTH:0] mul_sum_s;
    logic [WIDTH:0] div_shift_s;
    logic [WIDTH:0] div_diff_s;

    // Multiply: low half holds the unconsumed multiplier, high half accumulates.
    always_comb begin
        mul_sum_s = {1'b0, mul_prod[2*WIDTH-1:WIDTH]};
        if (mul_prod[0]) begin
            mul_sum_s = {1'b0, mul_prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_mcand};
        end else begin
            mul_sum_s = {1'b0, mul_prod[2*WIDTH-1:WIDTH]};
        end
        mul_prod_next = {mul_sum_s, mul_prod[WIDTH-1:1]};
    end

    // Divide: bring in the next dividend bit, keep the subtraction only if it did not borrow.
    always_comb begin
        div_shift_s   = (div_rem << 1) | {{WIDTH{1'b0}}, div_quot[WIDTH-1]};
        div_diff_s    = div_shift_s - {1'b0, div_divisor};
        div_rem_next  = div_shift_s;
        div_quot_next = {div_quot[WIDTH-2:0], 1'b0};
        if (div_diff_s[WIDTH]) begin
            div_rem_next  = div_shift_s;
            div_quot_next = {div_quot[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_next  = div_diff_s;
            div_quot_next = {div_quot[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit beside the EX-stage ALU. It stalls
// the pipeline while iterating and pulses o_done for the single cycle EXMA captures it.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_Op1,
    input  logic [WIDTH-1:0] i_Op2,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e            state_r;
    md_state_e            state_next_s;
    md_op_e               op_r;
    md_op_e               op_in_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     divisor_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH:0]       rem_r;
    logic [WIDTH-1:0]     quot_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     result_r;
    logic                 dbz_r;

    logic [2*WIDTH-1:0]   prod_next_s;
    logic [WIDTH:0]       rem_next_s;
    logic [WIDTH-1:0]     quot_next_s;
    logic [WIDTH-1:0]     finish_result_s;
    logic [WIDTH-1:0]     dbz_result_s;

    logic                 last_s;
    logic                 load_s;
    logic                 dbz_start_s;
    logic                 mul_iter_s;
    logic                 div_iter_s;
    logic                 finish_s;
    logic                 stall_s;
    logic                 done_s;

    assign op_in_s = md_op_e'(i_op);
    assign last_s  = (cnt_r == LAST_CNT);

    md_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mul_prod      (prod_r),
        .mul_mcand     (mcand_r),
        .div_rem       (rem_r),
        .div_quot      (quot_r),
        .div_divisor   (divisor_r),
        .mul_prod_next (prod_next_s),
        .div_rem_next  (rem_next_s),
        .div_quot_next (quot_next_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        dbz_start_s  = 1'b0;
        mul_iter_s   = 1'b0;
        div_iter_s   = 1'b0;
        finish_s     = 1'b0;
        stall_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            MD_ST_IDLE: begin
                if (i_start && !i_flush) begin
                    load_s  = 1'b1;
                    stall_s = 1'b1;
                    if (!md_is_div(op_in_s)) begin
                        state_next_s = MD_ST_MUL;
                    end else if (i_Op2 == {WIDTH{1'b0}}) begin
                        state_next_s = MD_ST_DONE;
                        dbz_start_s  = 1'b1;
                    end else begin
                        state_next_s = MD_ST_DIV;
                    end
                end else begin
                    state_next_s = MD_ST_IDLE;
                end
            end
            MD_ST_MUL: begin
                stall_s = 1'b1;
                if (i_flush) begin
                    state_next_s = MD_ST_IDLE;
                end else if (last_s) begin
                    mul_iter_s   = 1'b1;
                    finish_s     = 1'b1;
                    state_next_s = MD_ST_DONE;
                end else begin
                    mul_iter_s   = 1'b1;
                    state_next_s = MD_ST_MUL;
                end
            end
            MD_ST_DIV: begin
                stall_s = 1'b1;
                if (i_flush) begin
                    state_next_s = MD_ST_IDLE;
                end else if (last_s) begin
                    div_iter_s   = 1'b1;
                    finish_s     = 1'b1;
                    state_next_s = MD_ST_DONE;
                end else begin
                    div_iter_s   = 1'b1;
                    state_next_s = MD_ST_DIV;
                end
            end
            MD_ST_DONE: begin
                done_s       = !i_flush;
                state_next_s = MD_ST_IDLE;
            end
            default: begin
                state_next_s = MD_ST_IDLE;
            end
        endcase
    end

    // Result word chosen from the final iteration's outputs, ready for the DONE entry edge.
    always_comb begin
        finish_result_s = {WIDTH{1'b0}};
        case (op_r)
            MD_OP_MUL:   finish_result_s = prod_next_s[WIDTH-1:0];
            MD_OP_MULHU: finish_result_s = prod_next_s[2*WIDTH-1:WIDTH];
            MD_OP_DIVU:  finish_result_s = quot_next_s;
            MD_OP_REMU:  finish_result_s = rem_next_s[WIDTH-1:0];
            default:     finish_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Divide-by-zero short-circuit: quotient saturates, remainder is the dividend.
    always_comb begin
        dbz_result_s = {WIDTH{1'b1}};
        if (op_in_s == MD_OP_REMU) begin
            dbz_result_s = i_Op1;
        end else begin
            dbz_result_s = {WIDTH{1'b1}};
        end
    end

    // Operand, accumulator, counter and registered-result datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= MD_OP_MUL;
            mcand_r   <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            prod_r    <= {(2*WIDTH){1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            quot_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= {WIDTH{1'b0}};
            dbz_r     <= 1'b0;
        end else begin
            if (load_s) begin
                op_r      <= op_in_s;
                mcand_r   <= i_Op1;
                divisor_r <= i_Op2;
                prod_r    <= {{WIDTH{1'b0}}, i_Op2};
                rem_r     <= {(WIDTH+1){1'b0}};
                quot_r    <= i_Op1;
                cnt_r     <= {CNT_W{1'b0}};
                if (dbz_start_s) begin
                    result_r <= dbz_result_s;
                    dbz_r    <= 1'b1;
                end
            end else if (mul_iter_s) begin
                prod_r <= prod_next_s;
                cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (div_iter_s) begin
                rem_r  <= rem_next_s;
                quot_r <= quot_next_s;
                cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (finish_s) begin
                result_r <= finish_result_s;
                dbz_r    <= 1'b0;
            end
        end
    end

    assign o_stall       = stall_s;
    assign o_busy        = (state_r == MD_ST_MUL) || (state_r == MD_ST_DIV);
    assign o_done        = done_s;
    assign o_result      = result_r;
    assign o_div_by_zero = dbz_r;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: expected results are queued at issue time
// from a behavioural model and popped when o_done pulses.
module tb_ex_muldiv_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_Op1;
    logic [31:0] i_Op2;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_div_by_zero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_Op1         (i_Op1),
        .i_Op2         (i_Op2),
        .i_flush       (i_flush),
        .o_stall       (o_stall),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_div_by_zero (o_div_by_zero)
    );

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        logic [63:0] p;
        p     = {32'd0, a} * {32'd0, b};
        m.dbz = op[1] && (b == 32'd0);
        case (op)
            2'b00:   m.res = p[31:0];
            2'b01:   m.res = p[63:32];
            2'b10:   m.res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: m.res = (b == 32'd0) ? a : a % b;
        endcase
        return m;
    endfunction

    // Issue one op at cycle 0 (called at posedge+1 with the DUT idle).
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit keep_start);
        sb_q.push_back(model(op, a, b));
        i_start = 1'b1;
        i_op    = op;
        i_Op1   = a;
        i_Op2   = b;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b1) $display("FAIL stall_c0: got %b expected 1", o_stall);
        if (o_stall !== 1'b1) errors++;
        @(posedge clk);
        #1;
        if (keep_start) begin
            i_op  = 2'b00;
            i_Op1 = $urandom;
            i_Op2 = $urandom;
        end else begin
            i_start = 1'b0;
        end
    endtask

    // Follow cycles 1.. until o_done, checking stall profile, latency and scoreboard entry.
    task automatic wait_done(input int exp_cycle, input string name);
        int   cyc = 0;
        int   stall_bad = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && cyc < 80) begin
            cyc++;
            @(negedge clk);
            if (o_stall !== (cyc < exp_cycle)) stall_bad++;
            if (o_done === 1'b1) begin
                seen    = 1'b1;
                i_start = 1'b0;
                checks++;
                if (cyc != exp_cycle) begin
                    errors++;
                    $display("FAIL %s_latency: got cycle %0d expected %0d", name, cyc, exp_cycle);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_sb: got o_done expected no pending op", name);
                end else begin
                    e = sb_q.pop_front();
                    if (o_result !== e.res) begin
                        errors++;
                        $display("FAIL %s_result: got %h expected %h", name, o_result, e.res);
                    end
                    checks++;
                    if (o_div_by_zero !== e.dbz) begin
                        errors++;
                        $display("FAIL %s_dbz: got %b expected %b", name, o_div_by_zero, e.dbz);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no o_done expected one at cycle %0d", name, exp_cycle);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s_stall: got %0d bad stall cycles expected 0", name, stall_bad);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({o_result, o_div_by_zero, o_done, o_busy, o_stall} !== 36'd0) begin
            errors++;
            $display("FAIL %s: got res=%h dbz=%b done=%b busy=%b stall=%b expected all 0",
                     name, o_result, o_div_by_zero, o_done, o_busy, o_stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 1'b0; i_flush = 1'b0; i_op = 2'b00; i_Op1 = 32'd0; i_Op2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_state");
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        start_op(2'b00, 32'd7, 32'd6, 1'b0);
        wait_done(33, "mul_7x6");
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(33, "mulhu_max");
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(33, "mul_max");
    endtask

    task automatic test_div();
        start_op(2'b10, 32'd100, 32'd7, 1'b0);
        wait_done(33, "divu_100_7");
        start_op(2'b11, 32'd100, 32'd7, 1'b0);
        wait_done(33, "remu_100_7");
        start_op(2'b10, 32'd5, 32'd0, 1'b0);
        wait_done(1, "divu_by_zero");
        start_op(2'b11, 32'd5, 32'd0, 1'b0);
        wait_done(1, "remu_by_zero");
    endtask

    task automatic test_flush_mid();
        start_op(2'b00, 32'd3, 32'd3, 1'b0);
        sb_q.delete();
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_stall, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle: got stall=%b busy=%b expected 0 0", o_stall, o_busy);
        end
        begin
            int done_seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (o_done === 1'b1) done_seen++;
            end
            checks++;
            if (done_seen != 0) begin
                errors++;
                $display("FAIL flush_no_done: got %0d o_done pulses expected 0", done_seen);
            end
        end
        checks++;
        if (o_result !== 32'd5) begin
            errors++;
            $display("FAIL flush_result_held: got %h expected %h", o_result, 32'd5);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_done();
        start_op(2'b10, 32'd77, 32'd0, 1'b0);
        sb_q.delete();
        i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_done, o_stall} !== 2'b00) begin
            errors++;
            $display("FAIL flush_in_done: got done=%b stall=%b expected 0 0", o_done, o_stall);
        end
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_done_idle: got done=%b busy=%b expected 0 0", o_done, o_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        start_op(2'b10, 32'd1000, 32'd7, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_idle_zero("reset_mid_div");
        @(posedge clk);
        #1;
        start_op(2'b10, 32'd9, 32'd3, 1'b0);
        wait_done(33, "divu_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        start_op(2'b11, 32'd1234567, 32'd1000, 1'b1);
        wait_done(33, "start_held_ignored");
        for (int k = 0; k < 6; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (k == 3) ? 32'd0 : ((k % 2 == 0) ? 32'($urandom_range(1, 500)) : $urandom);
            start_op(op, a, b, 1'b0);
            wait_done((op[1] && b == 32'd0) ? 1 : 33, "b2b_rand");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush_mid();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
